// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Frame-rate game controller. Runs the IDLE/PLAY/HIT/OVER state
//             machine, holds the collision block in reset between games,
//             launches/advances/retires the single player bullet and keeps
//             the saturating score from meteor kills and star pickups.
//  Revision : 1.0  initial release
// ============================================================================
module game_sequencer #(
    parameter int LIVES_INIT    = 2,
    parameter int HIT_FRAMES    = 30,
    parameter int BULLET_SPEED  = 8,
    parameter int FIRE_COOLDOWN = 10,
    parameter int MET_PTS       = 1,
    parameter int STAR_PTS      = 5,
    parameter int SCORE_MAX     = 999
) (
    input  logic       v_sync,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       fire_btn,
    input  logic [9:0] ship_x,
    input  logic [9:0] ship_y,
    input  logic [1:0] lives,
    input  logic       m1_alive,
    input  logic       m2_alive,
    input  logic       m3_alive,
    input  logic       s1_alive,
    input  logic       s2_alive,
    output logic [1:0] state,
    output logic       coll_rst_n,
    output logic       freeze,
    output logic       flash,
    output logic       bullet_active,
    output logic [9:0] b_x,
    output logic [9:0] b_y,
    output logic [9:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Bullet spawns at the ship nose; the right screen edge retires it.
    localparam logic [10:0] c_x_limit     = 11'd628;
    localparam logic [10:0] c_bullet_xoff = 11'd30;
    localparam logic [9:0]  c_bullet_yoff = 10'd13;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      state_q,         state_d;
    logic        coll_rst_n_q,    coll_rst_n_d;
    logic        freeze_q,        freeze_d;
    logic        flash_q,         flash_d;
    logic        bullet_active_q, bullet_active_d;
    logic [9:0]  b_x_q,           b_x_d;
    logic [9:0]  b_y_q,           b_y_d;
    logic [9:0]  score_q,         score_d;
    logic [7:0]  cooldown_q,      cooldown_d;
    logic [5:0]  hit_timer_q,     hit_timer_d;
    logic        start_prev_q;
    logic        fire_prev_q;
    logic [1:0]  lives_prev_q,    lives_prev_d;
    logic [4:0]  alive_prev_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_start_rise;
    logic        w_fire_rise;
    logic [4:0]  w_alive_now;
    logic [4:0]  w_fell;
    logic [2:0]  w_met_kill;
    logic [1:0]  w_met_cnt;
    logic [1:0]  w_star_cnt;
    logic [11:0] w_score_sum;
    logic [9:0]  w_score_sat;
    logic        w_life_loss;
    logic [10:0] w_launch_x;
    logic        w_launch_ok;
    logic [10:0] w_bx_adv;
    logic        w_at_edge;

    assign w_start_rise = start_btn & ~start_prev_q;
    assign w_fire_rise  = fire_btn  & ~fire_prev_q;

    // Bit order {s2, s1, m3, m2, m1}; only 1->0 transitions count.
    assign w_alive_now  = {s2_alive, s1_alive, m3_alive, m2_alive, m1_alive};
    assign w_fell       = alive_prev_q & ~w_alive_now;
    assign w_met_kill   = w_fell[2:0] & {3{bullet_active_q}};
    assign w_met_cnt    = {1'b0, w_met_kill[0]} + {1'b0, w_met_kill[1]}
                        + {1'b0, w_met_kill[2]};
    assign w_star_cnt   = {1'b0, w_fell[3]} + {1'b0, w_fell[4]};

    assign w_score_sum  = {2'b00, score_q}
                        + ({10'd0, w_met_cnt}  * 12'(MET_PTS))
                        + ({10'd0, w_star_cnt} * 12'(STAR_PTS));
    assign w_score_sat  = (w_score_sum > 12'(SCORE_MAX)) ? 10'(SCORE_MAX)
                                                         : w_score_sum[9:0];

    assign w_life_loss  = (lives < lives_prev_q);

    assign w_launch_x   = {1'b0, ship_x} + c_bullet_xoff;
    assign w_launch_ok  = w_fire_rise & ~bullet_active_q & (cooldown_q == 8'd0)
                        & (w_launch_x < c_x_limit);

    assign w_bx_adv     = {1'b0, b_x_q} + 11'(BULLET_SPEED);
    assign w_at_edge    = (w_bx_adv >= c_x_limit);

    // Next-state, bullet, score and registered-output computation
    always_comb begin
        state_d         = state_q;
        hit_timer_d     = hit_timer_q;
        cooldown_d      = (cooldown_q != 8'd0) ? (cooldown_q - 8'd1) : 8'd0;
        bullet_active_d = bullet_active_q;
        b_x_d           = b_x_q;
        b_y_d           = b_y_q;
        score_d         = score_q;
        lives_prev_d    = lives_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start_rise) begin
                    state_d         = ST_PLAY;
                    score_d         = 10'd0;
                    lives_prev_d    = 2'(LIVES_INIT);
                    bullet_active_d = 1'b0;
                    b_x_d           = 10'd0;
                    b_y_d           = 10'd0;
                end
            end

            ST_PLAY: begin
                score_d = w_score_sat;
                if (w_life_loss) begin
                    // Life loss wins over everything else this frame.
                    lives_prev_d = lives;
                    if (bullet_active_q) begin
                        bullet_active_d = 1'b0;
                        cooldown_d      = 8'(FIRE_COOLDOWN);
                    end
                    if (lives == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d     = ST_HIT;
                        hit_timer_d = 6'(HIT_FRAMES - 1);
                    end
                end else if (w_met_kill != 3'b000) begin
                    bullet_active_d = 1'b0;
                    cooldown_d      = 8'(FIRE_COOLDOWN);
                end else if (bullet_active_q) begin
                    if (w_at_edge) begin
                        bullet_active_d = 1'b0;
                        cooldown_d      = 8'(FIRE_COOLDOWN);
                    end else begin
                        b_x_d = w_bx_adv[9:0];
                    end
                end else if (w_launch_ok) begin
                    bullet_active_d = 1'b1;
                    b_x_d           = w_launch_x[9:0];
                    b_y_d           = ship_y + c_bullet_yoff;
                end
            end

            ST_HIT: begin
                if (hit_timer_q == 6'd0) begin
                    state_d = ST_PLAY;
                end else begin
                    hit_timer_d = hit_timer_q - 6'd1;
                end
            end

            ST_OVER: begin
                if (w_start_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        coll_rst_n_d = (state_d != ST_IDLE);
        freeze_d     = (state_d != ST_PLAY);
        flash_d      = (state_d == ST_HIT) & hit_timer_d[2];
    end

    // Frame-rate state register with asynchronous reset
    always_ff @(posedge v_sync or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            coll_rst_n_q    <= 1'b0;
            freeze_q        <= 1'b1;
            flash_q         <= 1'b0;
            bullet_active_q <= 1'b0;
            b_x_q           <= 10'd0;
            b_y_q           <= 10'd0;
            score_q         <= 10'd0;
            cooldown_q      <= 8'd0;
            hit_timer_q     <= 6'd0;
            start_prev_q    <= 1'b0;
            fire_prev_q     <= 1'b0;
            lives_prev_q    <= 2'(LIVES_INIT);
            alive_prev_q    <= 5'b11111;
        end else begin
            state_q         <= state_d;
            coll_rst_n_q    <= coll_rst_n_d;
            freeze_q        <= freeze_d;
            flash_q         <= flash_d;
            bullet_active_q <= bullet_active_d;
            b_x_q           <= b_x_d;
            b_y_q           <= b_y_d;
            score_q         <= score_d;
            cooldown_q      <= cooldown_d;
            hit_timer_q     <= hit_timer_d;
            start_prev_q    <= start_btn;
            fire_prev_q     <= fire_btn;
            lives_prev_q    <= lives_prev_d;
            alive_prev_q    <= w_alive_now;
        end
    end

    assign state         = state_q;
    assign coll_rst_n    = coll_rst_n_q;
    assign freeze        = freeze_q;
    assign flash         = flash_q;
    assign bullet_active = bullet_active_q;
    assign b_x           = b_x_q;
    assign b_y           = b_y_q;
    assign score         = score_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_sequencer
//  Purpose  : Directed self-checking bench for game_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_sequencer;

    logic       v_sync;
    logic       rst;
    logic       start_btn;
    logic       fire_btn;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [1:0] lives;
    logic       m1_alive, m2_alive, m3_alive;
    logic       s1_alive, s2_alive;
    logic [1:0] state;
    logic       coll_rst_n;
    logic       freeze;
    logic       flash;
    logic       bullet_active;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic [9:0] score;

    int tests_run;
    int tests_failed;

    game_sequencer dut (
        .v_sync        (v_sync),
        .rst           (rst),
        .start_btn     (start_btn),
        .fire_btn      (fire_btn),
        .ship_x        (ship_x),
        .ship_y        (ship_y),
        .lives         (lives),
        .m1_alive      (m1_alive),
        .m2_alive      (m2_alive),
        .m3_alive      (m3_alive),
        .s1_alive      (s1_alive),
        .s2_alive      (s2_alive),
        .state         (state),
        .coll_rst_n    (coll_rst_n),
        .freeze        (freeze),
        .flash         (flash),
        .bullet_active (bullet_active),
        .b_x           (b_x),
        .b_y           (b_y),
        .score         (score)
    );

    initial v_sync = 1'b0;
    always #5 v_sync = ~v_sync;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: rising edge, then settle before inputs/outputs are touched.
    task automatic tick();
        @(posedge v_sync);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        start_btn = 1'b0;
        fire_btn  = 1'b0;
        ship_x    = 10'd100;
        ship_y    = 10'd200;
        lives     = 2'd2;
        m1_alive  = 1'b1; m2_alive = 1'b1; m3_alive = 1'b1;
        s1_alive  = 1'b1; s2_alive = 1'b1;

        // Reset values
        #12;
        check_eq("rst_state",  state, 0);
        check_eq("rst_collrn", coll_rst_n, 0);
        check_eq("rst_freeze", freeze, 1);
        check_eq("rst_flash",  flash, 0);
        check_eq("rst_bullet", bullet_active, 0);
        check_eq("rst_score",  score, 0);
        rst = 1'b0;
        tick();
        check_eq("idle_hold", state, 0);

        // Start game
        start_btn = 1'b1;
        tick();
        check_eq("start_state",  state, 1);
        check_eq("start_collrn", coll_rst_n, 1);
        check_eq("start_freeze", freeze, 0);
        check_eq("start_score",  score, 0);
        start_btn = 1'b0;
        tick();

        // Launch and first advance, fire held throughout flight
        fire_btn = 1'b1;
        tick();
        check_eq("launch_act", bullet_active, 1);
        check_eq("launch_bx",  b_x, 130);
        check_eq("launch_by",  b_y, 213);
        tick();
        check_eq("adv_bx", b_x, 138);
        for (int k = 0; k < 100 && bullet_active; k++) tick();
        check_eq("edge1_retired", bullet_active, 0);
        check_eq("edge1_bx_hold", b_x, 626);
        for (int k = 0; k < 12; k++) tick();
        check_eq("held_fire_norelaunch", bullet_active, 0);
        fire_btn = 1'b0;
        tick();

        // Second bullet reaching exactly 620, then cooldown
        ship_x   = 10'd110;
        fire_btn = 1'b1;
        tick();
        check_eq("launch2_bx", b_x, 140);
        fire_btn = 1'b0;
        for (int k = 0; k < 60; k++) tick();
        check_eq("bx_620", b_x, 620);
        check_eq("bx_620_act", bullet_active, 1);
        tick();
        check_eq("edge2_retired", bullet_active, 0);
        check_eq("edge2_bx_hold", b_x, 620);
        for (int k = 1; k <= 10; k++) begin
            fire_btn = k[0];
            tick();
            check_eq("cooldown_block", bullet_active, 0);
        end
        fire_btn = 1'b1;
        tick();
        check_eq("cooldown_launch", bullet_active, 1);
        check_eq("cooldown_launch_bx", b_x, 140);
        fire_btn = 1'b0;

        // Meteor kill plus star pickup in one frame
        m2_alive = 1'b0;
        s1_alive = 1'b0;
        tick();
        check_eq("kill_score", score, 6);
        check_eq("kill_retire", bullet_active, 0);
        check_eq("kill_bx_hold", b_x, 140);
        m2_alive = 1'b1;
        s1_alive = 1'b1;
        tick();
        check_eq("regen_noscore", score, 6);
        m1_alive = 1'b0;
        tick();
        check_eq("met_nobullet_noscore", score, 6);
        m1_alive = 1'b1;
        tick();

        // Life loss -> HIT for 30 frames
        lives = 2'd1;
        tick();
        check_eq("hit_state",  state, 2);
        check_eq("hit_freeze", freeze, 1);
        check_eq("hit_flash0", flash, 1);
        for (int i = 1; i < 30; i++) begin
            start_btn = i[0];
            tick();
            check_eq("hit_hold",  state, 2);
            check_eq("hit_flash", flash, ((29 - i) >> 2) & 1);
        end
        start_btn = 1'b0;
        tick();
        check_eq("hit_end_state",  state, 1);
        check_eq("hit_end_freeze", freeze, 0);
        check_eq("hit_end_flash",  flash, 0);

        // Last life -> OVER -> IDLE -> PLAY
        lives = 2'd0;
        tick();
        check_eq("over_state", state, 3);
        check_eq("over_freeze", freeze, 1);
        check_eq("over_score", score, 6);
        start_btn = 1'b1;
        tick();
        check_eq("over_idle", state, 0);
        check_eq("over_idle_collrn", coll_rst_n, 0);
        start_btn = 1'b0;
        lives = 2'd2;
        tick();
        check_eq("idle_wait", state, 0);
        start_btn = 1'b1;
        tick();
        check_eq("restart_state", state, 1);
        check_eq("restart_score", score, 0);
        check_eq("restart_collrn", coll_rst_n, 1);
        start_btn = 1'b0;
        tick();

        // Build score up to saturation
        for (int n = 0; n < 99; n++) begin
            s1_alive = 1'b0; s2_alive = 1'b0;
            tick();
            s1_alive = 1'b1; s2_alive = 1'b1;
            tick();
        end
        check_eq("score_990", score, 990);
        s1_alive = 1'b0;
        tick();
        check_eq("score_995", score, 995);
        s1_alive = 1'b1;
        ship_x   = 10'd100;
        fire_btn = 1'b1;
        tick();
        check_eq("launch3_act", bullet_active, 1);
        fire_btn = 1'b0;
        m1_alive = 1'b0; m3_alive = 1'b0;
        tick();
        check_eq("score_997", score, 997);
        m1_alive = 1'b1; m3_alive = 1'b1;
        s2_alive = 1'b0;
        tick();
        check_eq("score_sat", score, 999);
        s2_alive = 1'b1;
        tick();
        s1_alive = 1'b0;
        tick();
        check_eq("score_sat_hold", score, 999);
        s1_alive = 1'b1;
        tick();

        // Reset in the middle of HIT
        lives = 2'd1;
        tick();
        check_eq("hit2_state", state, 2);
        tick();
        tick();
        rst = 1'b1;
        #2;
        check_eq("mid_rst_state",  state, 0);
        check_eq("mid_rst_collrn", coll_rst_n, 0);
        check_eq("mid_rst_freeze", freeze, 1);
        check_eq("mid_rst_flash",  flash, 0);
        check_eq("mid_rst_bullet", bullet_active, 0);
        check_eq("mid_rst_bx",     b_x, 0);
        check_eq("mid_rst_by",     b_y, 0);
        check_eq("mid_rst_score",  score, 0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
